// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the instruction-fetch slice.
//   - Reset / chip-enable encodings used by the ROM interface.
//   - Default bus widths and prefetch depth.
//   - Fetch FSM state type.
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

   // Control encodings
   localparam logic RST_ENABLE   = 1'b1;
   localparam logic RST_DISABLE  = 1'b0;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   // Bus geometry
   localparam int INST_ADDR_BUS     = 32;
   localparam int INST_BUS          = 32;
   localparam int INST_MEM_NUM_LOG2 = 17;

   // Prefetch FIFO depth (power of two, >= 2)
   localparam int INST_FETCH_DEPTH = 4;

   typedef enum logic {
      S_RST = 1'b0,
      S_RUN = 1'b1
   } fetch_state_t;

endpackage : inst_fetch_pkg

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, inst} prefetch entries.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : write din at the edge (ignored when full or flushing)
//   pop      : remove head at the edge (ignored when empty or flushing)
//   flush    : discard all entries at the edge; overrides push and pop
//   din      : entry to write
//   dout     : head entry, zero when empty
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// ----------------------------------------------------------------------------
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = INST_FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full && !flush;
   assign pop_en  = pop && !empty && !flush;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two; count is kept
   // separately so full and empty never alias.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; stale contents are never visible
   // because dout is masked by empty and only written slots are ever read.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= din;
   end

endmodule : fetch_fifo

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Fetch-side initiator for the instruction ROM. Generates the PC, drives the
// ROM enable/address, captures the combinational ROM data in the same cycle
// into a prefetch FIFO, and hands {pc, inst} to decode over valid/ready.
// A decode redirect flushes the FIFO and restarts fetch at the target.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rom_ce_o          : ROM chip enable
//   rom_addr_o        : ROM byte address (always equals fetch_pc)
//   rom_inst_i        : ROM data, valid in the same cycle as rom_ce_o
//   branch_flag_i     : redirect request from decode (highest priority)
//   branch_target_i   : redirect byte address ([1:0] forced to zero)
//   id_ready_i        : decode accepts the head this cycle
//   id_valid_o        : head entry valid
//   id_pc_o, id_inst_o: head entry, zero when empty
//   fifo_count_o      : FIFO occupancy (debug)
// ----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int              ADDR_W     = INST_ADDR_BUS,
   parameter int              INST_W     = INST_BUS,
   parameter int              FIFO_DEPTH = INST_FETCH_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          rom_ce_o,
   output logic [ADDR_W-1:0]             rom_addr_o,
   input  logic [INST_W-1:0]             rom_inst_i,
   input  logic                          branch_flag_i,
   input  logic [ADDR_W-1:0]             branch_target_i,
   input  logic                          id_ready_i,
   output logic                          id_valid_o,
   output logic [ADDR_W-1:0]             id_pc_o,
   output logic [INST_W-1:0]             id_inst_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int ENTRY_W = ADDR_W + INST_W;

   fetch_state_t        state;
   logic [ADDR_W-1:0]   fetch_pc;
   logic                fifo_full;
   logic                fifo_empty;
   logic                redirect;
   logic                pop;
   logic [ENTRY_W-1:0]  head;

   // A redirect only counts once the FSM is running; the S_RST cycle ignores it.
   assign redirect   = (state == S_RUN) && branch_flag_i;
   assign rom_ce_o   = ((state == S_RUN) && !fifo_full && !branch_flag_i)
                       ? CHIP_ENABLE : CHIP_DISABLE;
   assign rom_addr_o = fetch_pc;
   assign pop        = id_valid_o && id_ready_i;

   assign id_valid_o = !fifo_empty;
   assign id_pc_o    = head[ENTRY_W-1:INST_W];
   assign id_inst_o  = head[INST_W-1:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state    <= S_RST;
         fetch_pc <= RESET_PC;
      end else begin
         case (state)
            S_RST: state <= S_RUN;
            S_RUN: begin
               if (branch_flag_i)
                  fetch_pc <= branch_target_i & ~ADDR_W'(3);
               else if (rom_ce_o == CHIP_ENABLE)
                  fetch_pc <= fetch_pc + ADDR_W'(4);   // wraps modulo 2^ADDR_W
            end
            default: state <= S_RST;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rom_ce_o == CHIP_ENABLE),
      .pop   (pop),
      .flush (redirect),
      .din   ({fetch_pc, rom_inst_i}),
      .dout  (head),
      .count (fifo_count_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule : inst_fetch
